// File: rtl/programmable_rate_divider.sv
// N_CH independent run-time programmable tick dividers on CLOCK_50 with a valid/ready config port.
// Optional feature macro: RDIV_STEP_EN adds a per-channel single-step input while a channel is paused.
module programmable_rate_divider #(
    parameter int unsigned WIDTH       = 26,
    parameter int unsigned N_CH        = 2,
    parameter int unsigned DEFAULT_DIV = 50_000_000,
    parameter int unsigned CHW         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             CLOCK_50,
    input  logic             resetn,
    input  logic [N_CH-1:0]  enable,
`ifdef RDIV_STEP_EN
    input  logic [N_CH-1:0]  step,
`endif
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CHW-1:0]   cfg_ch,
    input  logic [WIDTH-1:0] cfg_div,
    input  logic             cfg_oneshot,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  busy
);

    localparam logic [WIDTH-1:0] RstDiv = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] RstCnt = (DEFAULT_DIV < 2) ? '0 : WIDTH'(DEFAULT_DIV - 1);

    // Divisors below 2 behave as 1: the channel fires on every enabled edge.
    function automatic logic [WIDTH-1:0] reload_of(input logic [WIDTH-1:0] d);
        return (d < WIDTH'(2)) ? '0 : d - WIDTH'(1);
    endfunction

    logic             r_cfg_ready;
    logic             w_accept;
    logic [N_CH-1:0]  w_wr;
    logic [WIDTH-1:0] w_cfg_reload;

    assign w_accept     = cfg_valid & r_cfg_ready;
    assign w_cfg_reload = reload_of(cfg_div);
    assign cfg_ready    = r_cfg_ready;

    // Out-of-range channel numbers complete the handshake but select nothing.
    always_comb begin
        w_wr = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_accept && (cfg_ch == CHW'(i))) begin
                w_wr[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_cfg_ready <= 1'b1;
        end else begin
            r_cfg_ready <= ~w_accept;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [WIDTH-1:0] r_div;
        logic [WIDTH-1:0] r_cnt;
        logic             r_oneshot;
        logic             r_armed;
        logic             r_tick;
        logic             w_run;
        logic             w_tc;
        logic             w_step;

        assign w_run = enable[g] & r_armed;
        assign w_tc  = (r_cnt == '0);
`ifdef RDIV_STEP_EN
        assign w_step = step[g] & ~enable[g] & r_armed;
`else
        assign w_step = 1'b0;
`endif

        // A config write to this channel takes priority over a coincident terminal count.
        always_ff @(posedge CLOCK_50 or negedge resetn) begin
            if (!resetn) begin
                r_div     <= RstDiv;
                r_cnt     <= RstCnt;
                r_oneshot <= 1'b0;
                r_armed   <= 1'b1;
                r_tick    <= 1'b0;
            end else if (w_wr[g]) begin
                r_div     <= cfg_div;
                r_cnt     <= w_cfg_reload;
                r_oneshot <= cfg_oneshot;
                r_armed   <= 1'b1;
                r_tick    <= 1'b0;
            end else if (w_run) begin
                if (w_tc) begin
                    r_tick <= 1'b1;
                    r_cnt  <= reload_of(r_div);
                    if (r_oneshot) begin
                        r_armed <= 1'b0;
                    end
                end else begin
                    r_tick <= 1'b0;
                    r_cnt  <= r_cnt - WIDTH'(1);
                end
            end else if (w_step) begin
                r_tick <= 1'b1;
                if (r_oneshot) begin
                    r_armed <= 1'b0;
                end
            end else begin
                r_tick <= 1'b0;
            end
        end

        assign tick[g] = r_tick;
        assign busy[g] = w_run;
    end

endmodule

// File: tb/tb_programmable_rate_divider.sv
// Scoreboard bench for programmable_rate_divider: expected tick edges are queued per channel
// and a negedge monitor matches every observed tick against them.
module tb_programmable_rate_divider;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned N_CH  = 3;
    localparam int unsigned DDIV  = 5;

    logic             clk;
    logic             resetn;
    logic [N_CH-1:0]  enable;
`ifdef RDIV_STEP_EN
    logic [N_CH-1:0]  step;
`endif
    logic             cfg_valid;
    logic             cfg_ready;
    logic [1:0]       cfg_ch;
    logic [WIDTH-1:0] cfg_div;
    logic             cfg_oneshot;
    logic [N_CH-1:0]  tick;
    logic [N_CH-1:0]  busy;

    int cyc;
    int checks;
    int errors;
    int exp_q [N_CH][$];

    programmable_rate_divider #(
        .WIDTH      (WIDTH),
        .N_CH       (N_CH),
        .DEFAULT_DIV(DDIV)
    ) dut (
        .CLOCK_50   (clk),
        .resetn     (resetn),
        .enable     (enable),
`ifdef RDIV_STEP_EN
        .step       (step),
`endif
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_div    (cfg_div),
        .cfg_oneshot(cfg_oneshot),
        .tick       (tick),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge index since reset release; edge 1 is the first rising edge after release.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    // Monitor: every tick must match the head of its channel queue; overdue heads are misses.
    always @(negedge clk) begin
        if (resetn) begin
            for (int ch = 0; ch < N_CH; ch++) begin
                while (exp_q[ch].size() > 0 && exp_q[ch][0] < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL tick_missing ch%0d: got no tick, required tick at edge %0d",
                             ch, exp_q[ch][0]);
                    void'(exp_q[ch].pop_front());
                end
                if (tick[ch]) begin
                    checks++;
                    if (exp_q[ch].size() == 0 || exp_q[ch][0] != cyc) begin
                        errors++;
                        $display("FAIL tick_unexpected ch%0d: got tick at edge %0d, required %0d",
                                 ch, cyc, (exp_q[ch].size() == 0) ? -1 : exp_q[ch][0]);
                    end else begin
                        void'(exp_q[ch].pop_front());
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (edge %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic push_range(input int ch, input int first, input int last, input int inc);
        for (int e = first; e <= last; e += inc) exp_q[ch].push_back(e);
    endtask

    // Returns 1 ns after rising edge n; inputs set now are seen at edge n+1.
    task automatic at_edge(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cfg_write(input int n, input int ch, input int div, input bit os);
        at_edge(n - 1);
        check("ready_before_write", 32'(cfg_ready), 32'd1);
        cfg_valid   = 1'b1;
        cfg_ch      = 2'(ch);
        cfg_div     = WIDTH'(div);
        cfg_oneshot = os;
        at_edge(n);
        cfg_valid = 1'b0;
        check("ready_low_after_accept", 32'(cfg_ready), 32'd0);
        at_edge(n + 1);
        check("ready_back_high", 32'(cfg_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        checks      = 0;
        errors      = 0;
        resetn      = 1'b0;
        enable      = 3'b011;
        cfg_valid   = 1'b0;
        cfg_ch      = '0;
        cfg_div     = '0;
        cfg_oneshot = 1'b0;
`ifdef RDIV_STEP_EN
        step        = '0;
`endif
        #12;
        check("reset_tick", 32'(tick), 32'd0);
        check("reset_ready", 32'(cfg_ready), 32'd1);
        check("reset_busy", 32'(busy), 32'b011);

        // Default cadence on ch0/ch1; ch1 write at 20 collides with its terminal count.
        push_range(0, 5, 40, 5);
        push_range(1, 5, 15, 5);
        push_range(1, 23, 59, 3);
        @(negedge clk);
        resetn = 1'b1;
        cfg_write(20, 1, 3, 1'b0);

        // One-shot on ch0.
        exp_q[0].push_back(46);
        cfg_write(42, 0, 4, 1'b1);
        at_edge(45);
        check("oneshot_busy_before", 32'(busy[0]), 32'd1);
        at_edge(46);
        check("oneshot_busy_after", 32'(busy[0]), 32'd0);

        // Pause ch1 for edges 67..73 inside a div=5 period.
        exp_q[1].push_back(65);
        exp_q[1].push_back(77);
        exp_q[1].push_back(82);
        exp_q[1].push_back(87);
        cfg_write(60, 1, 5, 1'b0);
        at_edge(66);
        enable[1] = 1'b0;
        at_edge(67);
        check("paused_busy", 32'(busy[1]), 32'd0);
        at_edge(73);
        enable[1] = 1'b1;

        // div=0 and div=1 both tick every enabled edge; write at 96 suppresses that tick.
        push_range(1, 91, 95, 1);
        push_range(1, 97, 100, 1);
        cfg_write(90, 1, 0, 1'b0);
        cfg_write(96, 1, 1, 1'b0);
        at_edge(100);
        enable[1] = 1'b0;

        // Out-of-range channel: handshake only, ch2 keeps its reset state.
        cfg_write(104, 3, 2, 1'b1);
        push_range(2, 115, 120, 5);
        at_edge(110);
        enable[2] = 1'b1;
        at_edge(122);
        enable[2] = 1'b0;

`ifdef RDIV_STEP_EN
        push_range(2, 126, 130, 2);
        for (int k = 126; k <= 130; k += 2) begin
            at_edge(k - 1);
            step[2] = 1'b1;
            at_edge(k);
            step[2] = 1'b0;
        end
`endif
        // ch2 count was 2 when paused: resumes and fires at 143; step is ignored while enabled.
        exp_q[2].push_back(143);
        at_edge(140);
        enable[2] = 1'b1;
`ifdef RDIV_STEP_EN
        step[2] = 1'b1;
`endif
        at_edge(142);
`ifdef RDIV_STEP_EN
        step[2] = 1'b0;
`endif
        at_edge(143);
        enable[2] = 1'b0;

        // Asynchronous reset mid-count and mid-handshake.
        push_range(1, 146, 148, 1);
        at_edge(145);
        enable = 3'b010;
        at_edge(147);
        cfg_valid   = 1'b1;
        cfg_ch      = 2'd0;
        cfg_div     = WIDTH'(9);
        cfg_oneshot = 1'b0;
        at_edge(148);
        cfg_valid = 1'b0;
        check("ready_low_before_reset", 32'(cfg_ready), 32'd0);
        check("tick_high_before_reset", 32'(tick), 32'b010);
        #6;
        resetn = 1'b0;
        #1;
        check("async_reset_tick", 32'(tick), 32'd0);
        check("async_reset_ready", 32'(cfg_ready), 32'd1);
        check("async_reset_busy", 32'(busy), 32'b010);

        // Write in flight discarded: ch0 resumes default cadence.
        enable = 3'b001;
        repeat (2) @(negedge clk);
        push_range(0, 5, 10, 5);
        resetn = 1'b1;
        at_edge(12);
        enable = '0;
        repeat (5) @(negedge clk);

        for (int ch = 0; ch < N_CH; ch++) begin
            check($sformatf("queue_drained_ch%0d", ch), 32'(exp_q[ch].size()), 32'd0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/programmable_rate_divider.md
# programmable_rate_divider

Multi-channel, run-time-programmable successor to the bombe's fixed 0.25 Hz divider. It divides CLOCK_50 into N_CH independent tick streams. Each stream's period, free-run/one-shot mode and run state are set at run time through a valid/ready configuration port. Ticks are single-cycle, registered pulses in the CLOCK_50 domain. They drive rotor stepping, display refresh and the bombe's test-stop sampling.

## Interface
Parameters:
- WIDTH, 26, divisor/counter width in bits
- N_CH, 2, number of channels (≥1)
- DEFAULT_DIV, 50_000_000, divisor loaded into every channel at reset (1 Hz)
- CHW, (N_CH>1 ? $clog2(N_CH) : 1), channel-select width (derived, not overridden)

Ports:
- CLOCK_50  in  1  system clock, all logic on its rising edge
- resetn  in  1  asynchronous, active-low reset
- enable  in  N_CH  per-channel run enable; low = counter frozen
- cfg_valid  in  1  configuration write request
- cfg_ready  out  1  block can accept a write this cycle
- cfg_ch  in  CHW  target channel
- cfg_div  in  WIDTH  new divisor (period in CLOCK_50 cycles)
- cfg_oneshot  in  1  1 = channel fires once then disarms
- tick  out  N_CH  registered one-cycle pulse per channel period
- busy  out  N_CH  armed[i] & enable[i]

## Operation
- Per channel state: div[i] (WIDTH), cnt[i] (WIDTH), oneshot[i], armed[i].
- Effective divisor: if div < 2, effective divisor = 1, so the channel ticks every enabled cycle. Otherwise effective divisor = div.
- Enabled and armed channel, cnt ≠ 0: cnt decrements.
- Enabled and armed channel, cnt == 0: tick[i] is set for the next cycle and cnt reloads to effective divisor − 1. If oneshot[i] = 1, armed[i] clears.
- Disarmed one-shot channel: cnt holds its reload value, no ticks.
- enable[i] low: cnt holds and no tick, whatever the cnt value.
- Config handshake: a write is accepted on an edge where cfg_valid & cfg_ready.
  - On acceptance: div[cfg_ch] ← cfg_div, cnt ← effective divisor − 1, oneshot ← cfg_oneshot, armed ← 1.
  - cfg_ready drops for exactly the one cycle after an acceptance, then returns high. Back-to-back writes therefore complete every 2 cycles.
  - cfg_ch ≥ N_CH: the write is accepted (handshake completes) and no state changes.
- A write and a terminal count on the same channel and same edge: the write wins and no tick is produced. Other channels are unaffected.
- Reset (asserted any time, including mid-count or mid-handshake):
  - div = DEFAULT_DIV, cnt = DEFAULT_DIV−1, oneshot = 0, armed = 1
  - tick = 0, cfg_ready = 1, busy follows enable
  - a write in flight is discarded.

## Timing
- tick is a registered output, high for exactly one cycle per period.
- After reset release with enable[i] held high, the first tick[i] is high immediately after rising edge DEFAULT_DIV (counting the first edge after release as 1). Subsequent ticks follow every DEFAULT_DIV edges.
- Write accepted at edge k, enable high: first tick after edge k+div, then every div edges (one-shot: that single tick only).
- Pausing via enable extends the current period by exactly the number of disabled edges; phase is otherwise preserved.
- cfg_ready timing:
  - cfg_ready = 0 during cycle k+1 after acceptance at edge k.
  - cfg_valid may stay high; the next acceptance is at edge k+2.
- Timing closure at 50 MHz with WIDTH ≤ 32, N_CH ≤ 8.

## Configuration
- RDIV_STEP_EN defined:
  - adds port step (in, N_CH).
  - An edge with step[i]=1, enable[i]=0 and armed[i]=1 produces one tick[i] pulse, leaving cnt unchanged. For a one-shot channel it also clears armed.
  - step[i] is ignored while enable[i]=1 or during a config write to channel i.
- RDIV_STEP_EN undefined: step port absent; ticks come only from counting.

## Test plan
- Reset with DEFAULT_DIV overridden to 5, enable=2'b11 → tick on both channels after edges 5, 10, 15; tick=0, cfg_ready=1 while resetn=0.
- Write ch1 div=3 oneshot=0 at edge 20 → cfg_ready=0 for one cycle; tick[1] after edges 23, 26, 29; ch0 cadence unchanged.
- Write ch0 div=4 oneshot=1 → exactly one tick[0], 4 edges later; busy[0] falls with it; no further ticks for 50 cycles.
- With div=5, drop enable[1] for 7 edges mid-period → next tick[1] delayed by exactly 7 edges. Write div=0 and then div=1 → tick every enabled cycle.
- Write landing on the terminal-count edge → no tick that cycle, new period starts. Write with cfg_ch=3 (N_CH=2) → handshake completes, no state changes. Assert resetn mid-count → outputs reach reset values asynchronously.
- RDIV_STEP_EN: enable[0]=0, pulse step[0] 3 times → 3 tick[0] pulses, cnt unchanged. step[0] with enable[0]=1 → no extra tick.
